// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and helpers for the register-bank write arbiter.
// Holds the FSM state encoding, the default parameter values and a
// reference round-robin pick function usable by other arbiters.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        LOCKED = 2'd2
    } arb_state_t;

    localparam int DEF_N        = 32;
    localparam int DEF_NREQ     = 4;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_LOCK_MAX = 8;

    // Widest request vector the generic pick function handles.
    localparam int RR_MAX   = 32;
    localparam int RR_IDX_W = $clog2(RR_MAX);

    // One-hot winner: first set bit of req scanning upward from ptr,
    // wrapping at nreq. Returns all-zero when nothing is requested.
    function automatic logic [RR_MAX-1:0] rr_pick(
        input logic [RR_MAX-1:0] req,
        input int unsigned       ptr,
        input int unsigned       nreq = DEF_NREQ
    );
        logic [RR_MAX-1:0] oh;
        logic              found;
        int unsigned       idx;
        oh    = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < RR_MAX; k++) begin
            if (k < nreq) begin
                idx = (ptr + k) % nreq;
                if (!found && req[idx[RR_IDX_W-1:0]]) begin
                    oh[idx[RR_IDX_W-1:0]] = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_picker.sv
// Combinational round-robin picker: rotate the request vector so ptr
// sits at bit 0, find the first set bit, then rotate the index back.
// Generic in NREQ so other arbiters can reuse it.
module rr_picker #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    found
);
    localparam int PTR_W = $clog2(NREQ);
    localparam logic [PTR_W:0] NREQ_V = NREQ[PTR_W:0];

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [PTR_W-1:0]  ffs;
    logic [PTR_W:0]    sum;

    // Rotate, priority-encode from the bottom, unrotate modulo NREQ.
    always_comb begin
        dbl   = {req, req};
        rot   = dbl[ptr +: NREQ];
        ffs   = '0;
        found = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                ffs   = PTR_W'(i);
                found = 1'b1;
            end
        end
        sum = {1'b0, ptr} + {1'b0, ffs};
        if (sum >= NREQ_V) begin
            sum = sum - NREQ_V;
        end
        idx = sum[PTR_W-1:0];
        gnt = '0;
        if (found) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Single write port arbiter for the CPU register bank. Round-robin
// among NREQ requesters, with a bounded lock so a holder can burst up
// to LOCK_MAX consecutive writes. Grant and bank write are registered.
// Optional macro REG_ARB_PRIO_EN: requester 0 wins every arbitration
// point where it requests, without moving the round-robin pointer.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int NREQ     = DEF_NREQ,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int LOCK_MAX = DEF_LOCK_MAX
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      lock,
    input  logic [NREQ*ADDR_W-1:0] wr_addr,
    input  logic [NREQ*N-1:0]    wr_data,
    output logic [NREQ-1:0]      gnt,
    output logic                 we,
    output logic [ADDR_W-1:0]    addr,
    output logic [N-1:0]         data,
    output logic                 busy
);
    localparam int PTR_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LOCK_MAX - 1);

    arb_state_t       state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] hold_idx;
    logic [CNT_W-1:0] lock_cnt;

    logic             hold_req;
    logic             hold_lock;
    logic             rel;
    logic [NREQ-1:0]  others;
    logic [NREQ-1:0]  cand;
    logic [NREQ-1:0]  pick_oh;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_found;
    logic [NREQ-1:0]  win_oh;
    logic [PTR_W-1:0] win_idx;
    logic             win_found;
    logic [PTR_W-1:0] ptr_nxt;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .req   (cand),
        .ptr   (ptr),
        .gnt   (pick_oh),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Release detection and next-holder selection; a releasing holder is
    // only a candidate again when nobody else is requesting.
    always_comb begin
        hold_req  = |(req & gnt);
        hold_lock = |(lock & gnt);
        rel       = (state == IDLE) || !hold_req || !hold_lock || (lock_cnt == LAST);
        others    = req & ~gnt;
        cand      = (|others) ? others : req;
        win_oh    = pick_oh;
        win_idx   = pick_idx;
        win_found = pick_found;
        ptr_nxt   = (pick_idx == PTR_W'(NREQ - 1)) ? '0 : pick_idx + PTR_W'(1);
`ifdef REG_ARB_PRIO_EN
        if (req[0]) begin
            win_oh    = {{(NREQ-1){1'b0}}, 1'b1};
            win_idx   = '0;
            win_found = 1'b1;
            ptr_nxt   = ptr;
        end
`endif
    end

    // FSM, round-robin pointer, lock counter and registered bank write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            gnt      <= '0;
            busy     <= 1'b0;
            we       <= 1'b0;
            addr     <= '0;
            data     <= '0;
            ptr      <= '0;
            hold_idx <= '0;
            lock_cnt <= '0;
        end else begin
            we <= hold_req;
            if (hold_req) begin
                addr <= wr_addr[hold_idx*ADDR_W +: ADDR_W];
                data <= wr_data[hold_idx*N +: N];
            end
            if (rel) begin
                lock_cnt <= '0;
                if (win_found) begin
                    state    <= GRANT;
                    gnt      <= win_oh;
                    busy     <= 1'b1;
                    hold_idx <= win_idx;
                    ptr      <= ptr_nxt;
                end else begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            end else begin
                state    <= LOCKED;
                lock_cnt <= lock_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter (NREQ=4, N=32, ADDR_W=5, LOCK_MAX=8).
module tb_reg_write_arbiter;
    localparam int N        = 32;
    localparam int NREQ     = 4;
    localparam int ADDR_W   = 5;
    localparam int LOCK_MAX = 8;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        lock;
    logic [NREQ*ADDR_W-1:0] wr_addr;
    logic [NREQ*N-1:0]      wr_data;
    logic [NREQ-1:0]        gnt;
    logic                   we;
    logic [ADDR_W-1:0]      addr;
    logic [N-1:0]           data;
    logic                   busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    reg_write_arbiter #(.N(N), .NREQ(NREQ), .ADDR_W(ADDR_W), .LOCK_MAX(LOCK_MAX)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .lock    (lock),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .gnt     (gnt),
        .we      (we),
        .addr    (addr),
        .data    (data),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        req     = 4'b1111;
        lock    = 4'b0000;
        for (int i = 0; i < NREQ; i++) begin
            wr_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(i + 1);
            wr_data[i*N +: N]           = 32'h0000_00A0 + 32'(i);
        end
        step();
        step();
        total_cnt++; if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", gnt); else pass_cnt++;
        total_cnt++; if (we !== 1'b0) $display("FAIL reset_we: got %b want 0", we); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (addr !== 5'd0) $display("FAIL reset_addr: got %0d want 0", addr); else pass_cnt++;
        total_cnt++; if (data !== 32'd0) $display("FAIL reset_data: got %h want 0", data); else pass_cnt++;
        reset = 1'b1;
        step();
        total_cnt++; if (gnt !== 4'b0001) $display("FAIL first_gnt: got %b want 0001", gnt); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL first_busy: got %b want 1", busy); else pass_cnt++;
        total_cnt++; if (we !== 1'b0) $display("FAIL first_we: got %b want 0", we); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt;
        logic [4:0] exp_addr;
        req  = 4'b1111;
        lock = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            step();
            exp_gnt  = 4'b0001 << ((k + 1) % 4);
            exp_addr = 5'((k % 4) + 1);
            total_cnt++; if (gnt !== exp_gnt) $display("FAIL rr_gnt[%0d]: got %b want %b", k, gnt, exp_gnt); else pass_cnt++;
            total_cnt++; if (we !== 1'b1) $display("FAIL rr_we[%0d]: got %b want 1", k, we); else pass_cnt++;
            total_cnt++; if (addr !== exp_addr) $display("FAIL rr_addr[%0d]: got %0d want %0d", k, addr, exp_addr); else pass_cnt++;
        end
    endtask

    task automatic test_prio();
        logic [3:0] exp_gnt;
        reset = 1'b0;
        req   = 4'b1111;
        lock  = 4'b0000;
        step();
        reset = 1'b1;
        step();
        total_cnt++; if (gnt !== 4'b0001) $display("FAIL prio_first_gnt: got %b want 0001", gnt); else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            step();
            total_cnt++; if (gnt !== 4'b0001) $display("FAIL prio_gnt[%0d]: got %b want 0001", k, gnt); else pass_cnt++;
            total_cnt++; if (we !== 1'b1 || addr !== 5'd1) $display("FAIL prio_wr[%0d]: got we=%b addr=%0d want we=1 addr=1", k, we, addr); else pass_cnt++;
        end
        req = 4'b1110;
        for (int k = 0; k < 4; k++) begin
            step();
            exp_gnt = 4'b0010 << (k % 3);
            total_cnt++; if (gnt !== exp_gnt) $display("FAIL prio_rr_gnt[%0d]: got %b want %b", k, gnt, exp_gnt); else pass_cnt++;
        end
    endtask

    task automatic test_lock_burst();
        logic [3:0] exp_gnt;
        reset = 1'b0;
        req   = 4'b0000;
        lock  = 4'b0000;
        step();
        reset = 1'b1;
        wr_addr[2*ADDR_W +: ADDR_W] = 5'd7;
        wr_data[2*N +: N]           = 32'hDEAD_BEEF;
        wr_addr[1*ADDR_W +: ADDR_W] = 5'd3;
        wr_data[1*N +: N]           = 32'h1111_1111;
        req  = 4'b0100;
        lock = 4'b0100;
        step();
        total_cnt++; if (gnt !== 4'b0100) $display("FAIL lock_grant: got %b want 0100", gnt); else pass_cnt++;
        req = 4'b0110;
        for (int k = 1; k <= LOCK_MAX; k++) begin
            step();
            exp_gnt = (k < LOCK_MAX) ? 4'b0100 : 4'b0010;
            total_cnt++; if (we !== 1'b1 || addr !== 5'd7 || data !== 32'hDEAD_BEEF)
                $display("FAIL lock_wr[%0d]: got we=%b addr=%0d data=%h want we=1 addr=7 data=deadbeef", k, we, addr, data);
            else pass_cnt++;
            total_cnt++; if (gnt !== exp_gnt) $display("FAIL lock_gnt[%0d]: got %b want %b", k, gnt, exp_gnt); else pass_cnt++;
        end
        req  = 4'b0010;
        lock = 4'b0000;
        step();
        total_cnt++; if (we !== 1'b1 || addr !== 5'd3 || data !== 32'h1111_1111)
            $display("FAIL lock_next_wr: got we=%b addr=%0d data=%h want we=1 addr=3 data=11111111", we, addr, data);
        else pass_cnt++;
        req = 4'b0000;
        step();
        total_cnt++; if (gnt !== 4'b0000 || we !== 1'b0 || busy !== 1'b0)
            $display("FAIL lock_idle: got gnt=%b we=%b busy=%b want 0000 0 0", gnt, we, busy);
        else pass_cnt++;
    endtask

    task automatic test_solo();
        wr_data[3*N +: N] = 32'h1234_5678;
        req  = 4'b1000;
        lock = 4'b0000;
        step();
        total_cnt++; if (gnt !== 4'b1000) $display("FAIL solo_grant: got %b want 1000", gnt); else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            step();
            total_cnt++; if (gnt !== 4'b1000) $display("FAIL solo_gnt[%0d]: got %b want 1000", k, gnt); else pass_cnt++;
            total_cnt++; if (we !== 1'b1 || data !== 32'h1234_5678)
                $display("FAIL solo_wr[%0d]: got we=%b data=%h want we=1 data=12345678", k, we, data);
            else pass_cnt++;
        end
        req = 4'b0000;
        step();
        step();
    endtask

    task automatic test_reset_mid_burst();
        req  = 4'b0100;
        lock = 4'b0100;
        step();
        total_cnt++; if (gnt !== 4'b0100) $display("FAIL mid_grant: got %b want 0100", gnt); else pass_cnt++;
        for (int k = 0; k < 4; k++) step();
        total_cnt++; if (we !== 1'b1 || addr !== 5'd7) $display("FAIL mid_pre_wr: got we=%b addr=%0d want we=1 addr=7", we, addr); else pass_cnt++;
        #2;
        reset = 1'b0;
        #1;
        total_cnt++; if (gnt !== 4'b0000 || we !== 1'b0 || addr !== 5'd0 || data !== 32'd0 || busy !== 1'b0)
            $display("FAIL mid_async: got gnt=%b we=%b addr=%0d data=%h busy=%b want all zero", gnt, we, addr, data, busy);
        else pass_cnt++;
        step();
        total_cnt++; if (we !== 1'b0) $display("FAIL mid_no_we: got %b want 0", we); else pass_cnt++;
        req   = 4'b1111;
        lock  = 4'b0000;
        reset = 1'b1;
        step();
        total_cnt++; if (gnt !== 4'b0001) $display("FAIL mid_restart: got %b want 0001", gnt); else pass_cnt++;
        total_cnt++; if (we !== 1'b0) $display("FAIL mid_restart_we: got %b want 0", we); else pass_cnt++;
    endtask

    initial begin
        test_reset();
`ifdef REG_ARB_PRIO_EN
        test_prio();
`else
        test_round_robin();
`endif
        test_lock_burst();
        test_solo();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Shares the single write port of the CPU's 32-bit register bank, built from `dff` cells, among up to NREQ requesters. Candidate requesters are the writeback stage, the load unit and the debug/init loader. It performs round-robin arbitration with a bounded lock for back-to-back burst writes. It drives one registered write (enable, address, data) per cycle into the bank. It sits between the pipeline's writeback logic and the register-bank write port.

## Interface
Parameters:
- `N`, default 32: data width in bits.
- `NREQ`, default 4: number of requesters. Must be 2 or more.
- `ADDR_W`, default 5: register address width.
- `LOCK_MAX`, default 8: maximum number of consecutive granted cycles per tenure.

Ports:
- `clk`, input, 1 bit: rising-edge clock.
- `reset`, input, 1 bit: asynchronous, active-low reset.
- `req`, input, NREQ bits: per-requester write request.
- `lock`, input, NREQ bits: the holder asks to keep the grant for the next cycle.
- `wr_addr`, input, NREQ*ADDR_W bits: packed per-requester address. Requester i uses slice `[i*ADDR_W +: ADDR_W]`.
- `wr_data`, input, NREQ*N bits: packed per-requester data. Requester i uses slice `[i*N +: N]`.
- `gnt`, output, NREQ bits: registered grant, one-hot or all-zero.
- `we`, output, 1 bit: registered bank write enable.
- `addr`, output, ADDR_W bits: registered bank write address.
- `data`, output, N bits: registered bank write data.
- `busy`, output, 1 bit: high whenever `gnt` is nonzero.

## Operation
- **Handshake.** A write from requester i is accepted on a rising edge where `req[i]` and `gnt[i]` are both high. The requester must hold `req`, `wr_addr` and `wr_data` stable until it is accepted.
- **State machine.**
  - IDLE: `gnt` = 0.
  - GRANT: first granted cycle; `lock_cnt` = 0.
  - LOCKED: `lock_cnt` > 0.
- **Arbitration point.** Arbitration happens at any edge in IDLE, and at any edge where the holder releases. The holder releases when any of these is true:
  - `req` is low,
  - `lock` is low,
  - `lock_cnt` = LOCK_MAX-1.
- **Round-robin pick.** The next holder is the first set bit of `req`, scanning upward from `ptr` with wrap-around. `ptr` becomes winner+1 mod NREQ.
  - A releasing holder may win again only if no other requester is requesting.
  - If nothing is requested, the next state is IDLE.
- **Burst lock.** Holding `lock` and `req` continuously gives at most LOCK_MAX consecutive accepted writes.
- **Write path.** On every accepted edge: `we` <= 1, `addr` <= the holder's `wr_addr` slice, `data` <= the holder's `wr_data` slice. Otherwise `we` <= 0 and `addr`/`data` hold their values.
- **Ignored inputs.** `lock` from a requester that does not hold the grant is ignored.
- **Reset values (asynchronous, while `reset` = 0):** `gnt` = 0, `we` = 0, `addr` = 0, `data` = 0, `busy` = 0, `ptr` = 0, `lock_cnt` = 0, state = IDLE.
- **Reset mid-burst.** Reset during a burst drops the in-flight write. No `we` pulse is produced after reset asserts.

## Timing
- Request to grant: 1 cycle. `req` rises before edge k, `gnt` is high after edge k, and the first accept happens at edge k+1.
- Accept to bank write: 1 cycle. `we`, `addr` and `data` are valid after the accepting edge, for one cycle per accepted write.
- Holder change: no bubble. The release edge grants the next requester directly, with no IDLE cycle in between.
- Maximum wait for any continuously requesting requester: (NREQ-1)*LOCK_MAX + 1 cycles.
- The only combinational path is the next-grant logic from `req`/`lock` to the grant flops. All outputs are driven straight from flops.

## Configuration
- Macro: `REG_ARB_PRIO_EN`.
- Defined: requester 0 wins every arbitration point where `req[0]` is high.
  - A win by requester 0 leaves `ptr` unchanged.
  - Requester 0 cannot preempt an active lock; it wins at the next release.
- Undefined: pure round-robin as described above.

## Structure
- Package `reg_arb_pkg` holds:
  - the state enum `arb_state_t` (IDLE, GRANT, LOCKED),
  - the default parameter constants,
  - the function `rr_pick(req, ptr)`, which returns a one-hot winner.
- One sub-module, `rr_picker`: a combinational rotate, find-first and unrotate block. It is reusable by other arbiters in the design.
- The top level contains the FSM, `ptr`, `lock_cnt` and the output flops.

## Test plan
1. Hold `reset` = 0 with `req` = 4'b1111. Expect `gnt` = 0 and `we` = 0. Release reset; `gnt` = 4'b0001 one cycle later.
2. Drive `req` = 4'b1111 with `lock` = 0 for 8 cycles. Expect `gnt` to cycle 0001, 0010, 0100, 1000, 0001 with no idle cycles, and `we` high every cycle from the second cycle on.
3. Requester 2 requests with `lock[2]` = 1, `wr_addr` = 5'd7, `wr_data` = 32'hDEAD_BEEF, while requester 1 also requests. Expect exactly 8 writes `addr` = 7, `data` = DEAD_BEEF, then `gnt` = 4'b0010.
4. Requester 3 requests alone with `lock` = 0 and `wr_data` = 32'h1234_5678. Expect re-grant to 3 every cycle and `we` held high with `data` = 32'h1234_5678.
5. Assert `reset` mid-burst at cycle 4 of a lock. Expect `gnt`, `we`, `addr` and `data` to go to 0 asynchronously, and arbitration to restart from `ptr` = 0.
6. With `REG_ARB_PRIO_EN` defined and `req` = 4'b1111, `lock` = 0: expect `gnt` = 4'b0001 every cycle. Drop `req[0]` and expect round-robin among 1, 2 and 3.
